gate_exerciser: RTL
===================

# gate_exerciser

Self-checking exerciser for the 3-input complex gate (ABC = A&(B|C), two outputs ABC_1 and ABC_2). It drives the gate's inputs and reads its outputs.

- **Drive:** walks the gate's A, B, C inputs through all 8 combinations, in the same binary ordering as the gate's clock-style stimulus: A fastest, C middle, B slowest.
- **Check:** samples both gate outputs after a programmable settle time and compares each against the golden function.
- **Report:** mismatch count, first failing vector, and a pass flag, behind a start/done handshake.
- **Placement:** sits beside the gate in the digital lab top level, replacing free-running simulation stimulus with a synthesizable checker.

## Interface
Parameters:
- SETTLE, default 2: cycles the vector is held before sampling; legal range 1..15.
- PASSES, default 1: number of full 8-vector sweeps per run; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; level-sampled.
- A  out  1  drive to gate input A (vector bit 0).
- C  out  1  drive to gate input C (vector bit 1).
- B  out  1  drive to gate input B (vector bit 2).
- ABC_1  in  1  gate output 1, to be checked.
- ABC_2  in  1  gate output 2, to be checked.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next accepted start.
- pass  out  1  err_count==0; valid only while done=1, otherwise 0.
- err_count  out  4  failing vectors; saturates at 15.
- fail_vec  out  3  first failing vector {B,C,A}; 0 if none.

## Operation
- **Reset:** async. State→IDLE. A, B, C, busy, done, pass, err_count, fail_vec all 0. Internal vector, settle and pass counters are 0.
- **Vector:** 3-bit counter v. Outputs are A=v[0], C=v[1], B=v[2].
- **Expected value:** exp = A&(B|C), i.e. 1 for v=3, 5, 7. Both ABC_1 and ABC_2 must equal exp.
- **States:** IDLE, SETTLE, CHECK, DONE.
- IDLE: on start=1, load v=0, clear the error counter and fail_vec, busy←1, go to SETTLE.
- SETTLE: hold the vector for SETTLE cycles, then go to CHECK.
- CHECK (one cycle): sample ABC_1/ABC_2 and compare.
  - Mismatch on either output counts as one error for that vector.
  - On the first error of the run, capture v into fail_vec.
  - If v==7 and this is the last pass: go to DONE, busy←0, done←1.
  - If v==7 and passes remain: v wraps to 0 and the pass counter increments.
  - Otherwise v←v+1, back to SETTLE.
- DONE: done=1, pass=(err_count==0). A, B, C hold the last vector (7). start=1 restarts exactly as from IDLE, with done←0 on the same edge.
- Start is ignored while busy. Start held high in DONE causes back-to-back runs.
- Error counter saturates at 15 and never wraps.
- Reset mid-run aborts immediately to the reset values. No partial results are kept.

## Timing
- All outputs are registered. There is no combinational path from ABC_1/ABC_2 to any output.
- The edge that accepts start also drives vector 0 onto A, B, C.
- Per vector: SETTLE+1 cycles.
- Run length: 8·(SETTLE+1)·PASSES cycles from the accept edge to the edge asserting done. This is 24 cycles at the defaults.
- Each vector is sampled on its CHECK cycle edge, SETTLE+1 cycles after it was driven. The gate's propagation delay must fit in that window.
- err_count and fail_vec update on the CHECK edge; pass updates on the same edge as done.

## Structure
- Package gate_exerciser_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - VEC_W=3 and ERR_W=4;
  - the golden function exp(v) returning v[0]&(v[1]|v[2]).
- One sub-module, gate_golden: combinational reference model taking {B,C,A} and returning the expected values for ABC_1 and ABC_2. It is reused by the bench scoreboard.
- The FSM and counters live in gate_exerciser itself.

## Test plan
- **Loopback:** real gate model (A&(B|C)), defaults, start pulse → done after 24 cycles; pass=1, err_count=0, fail_vec=0.
- **Stuck-at-0 on ABC_1:** → done with err_count=3, fail_vec=3'b011, pass=0. ABC_2 is correct throughout.
- **Inverted ABC_2:** → err_count=8, fail_vec=0, pass=0. With PASSES=2 → err_count=15 (saturated), not 0.
- **Reset mid-run:** rst pulse at cycle 10 → all outputs 0 within the same cycle, state IDLE. A following start completes normally with pass=1.
- **Start handling:** start pulse at cycle 5 while busy → no effect, done still at cycle 24. start held high through DONE → done=1 for exactly one cycle, then a new run begins with vector 0.
- **Short settle, two passes:** SETTLE=1, PASSES=2, loopback → done after 32 cycles, pass=1. The A/C/B waveforms show periods 4/8/16 cycles.

Source files
------------

// File: rtl/gate_exerciser_pkg.sv
// rtl/gate_exerciser_pkg.sv - shared types, widths and golden function for the gate exerciser
package gate_exerciser_pkg;

  localparam int VEC_W = 3;
  localparam int ERR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Golden complex gate: vector is {B,C,A}, result is A&(B|C)
  function automatic logic exp(input logic [VEC_W-1:0] v);
    return v[0] & (v[1] | v[2]);
  endfunction

endpackage

// File: rtl/gate_golden.sv
// rtl/gate_golden.sv - combinational reference model of both gate outputs
module gate_golden
  import gate_exerciser_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             abc_1_o,
  output logic             abc_2_o
);

  // Both gate outputs implement the same function
  assign abc_1_o = exp(vec_i);
  assign abc_2_o = exp(vec_i);

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - walks all gate input vectors and checks both outputs
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int PASSES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             A,
  output logic             C,
  output logic             B,
  input  logic             ABC_1,
  input  logic             ABC_2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0]       PASS_LAST   = 4'(PASSES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = '1;
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e           state_q;
  logic [VEC_W-1:0] v_q;
  logic [VEC_W-1:0] v_d;
  logic [3:0]       settle_cnt_q;
  logic [3:0]       pass_cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [VEC_W-1:0] fail_vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             exp_1;
  logic             exp_2;
  logic             mismatch;

  gate_golden u_golden (
    .vec_i   (v_q),
    .abc_1_o (exp_1),
    .abc_2_o (exp_2)
  );

  // Next vector and saturating error count, used only on the CHECK edge
  always_comb begin
    v_d      = v_q + 1'b1;
    mismatch = (ABC_1 != exp_1) || (ABC_2 != exp_2);
    err_d    = err_q;
    if (mismatch && (err_q != ERR_MAX)) begin
      err_d = err_q + 1'b1;
    end
  end

  // Run sequencer: accept start, settle, check each vector, report
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      v_q          <= '0;
      settle_cnt_q <= '0;
      pass_cnt_q   <= '0;
      err_q        <= '0;
      fail_vec_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_SETTLE;
            v_q          <= '0;
            settle_cnt_q <= '0;
            pass_cnt_q   <= '0;
            err_q        <= '0;
            fail_vec_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_q <= '0;
            state_q      <= ST_CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        ST_CHECK: begin
          err_q <= err_d;
          // err_q stays nonzero once set, so this captures only the first failure
          if (mismatch && (err_q == '0)) begin
            fail_vec_q <= v_q;
          end
          if (v_q == VEC_LAST) begin
            if (pass_cnt_q == PASS_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              v_q        <= '0;
              pass_cnt_q <= pass_cnt_q + 1'b1;
              state_q    <= ST_SETTLE;
            end
          end else begin
            v_q     <= v_d;
            state_q <= ST_SETTLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign A         = v_q[0];
  assign C         = v_q[1];
  assign B         = v_q[2];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_vec_q;

endmodule
